mac_tile_ctrl: RTL and testbench

Sequencing controller for the 4-lane MAC datapath (mac_wrapper: four chained MACs plus a psum-in adder).
- Accepts a stream of 4-element x/w groups over a valid/ready handshake and drives them into the datapath one group per beat.
- Feeds the running partial sum back on psum_in and holds the result in an accumulator register.
- Emits the final dot product over a valid/ready output handshake.
- Sits between the operand buffers/SRAM reader and the result writer.

---
 rtl/mac_ctrl_pkg.sv | 8 +
 rtl/mac_tile_ctrl.sv | 87 ++++++++
 tb/tb_mac_tile_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/mac_ctrl_pkg.sv
// mac_ctrl_pkg: shared lane count, FSM state encoding and lane-slice helper for mac_tile_ctrl
package mac_ctrl_pkg;
    localparam int LANES = 4;
    typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, OUT = 2'd2} state_e;
    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction
endpackage

// File: rtl/mac_tile_ctrl.sv
// mac_tile_ctrl: sequences 4-lane x/w groups into an external MAC datapath and emits the accumulated dot product
// Ports: clk/reset_n (async active-low); start+num_grp launch a job, busy while not idle;
//        in_valid/in_ready/in_x/in_w operand handshake; mac_x/mac_w/mac_psum drive the datapath,
//        mac_out returns its combinational result; out_valid/out_ready/out_data result handshake.
// Optional (MAC_TILE_CTRL_STALL_CNT_EN): stall_cnt counts saturating input-starved ACC cycles per job.
module mac_tile_ctrl
    import mac_ctrl_pkg::*;
#(
    parameter int bw      = 4,
    parameter int psum_bw = 16,
    parameter int len_bw  = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [len_bw-1:0]     num_grp,
    output logic                  busy,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*bw-1:0]   in_x,
    input  logic [LANES*bw-1:0]   in_w,
    output logic [LANES*bw-1:0]   mac_x,
    output logic [LANES*bw-1:0]   mac_w,
    output logic [psum_bw-1:0]    mac_psum,
    input  logic [psum_bw-1:0]    mac_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [psum_bw-1:0]    out_data
`ifdef MAC_TILE_CTRL_STALL_CNT_EN
    ,
    output logic [15:0]           stall_cnt
`endif
);
    state_e              state_q, state_d;
    logic [psum_bw-1:0]  acc_q, acc_d;
    logic [len_bw-1:0]   cnt_q, cnt_d;
    logic                in_acc;
    assign in_acc    = state_q == ACC;
    assign busy      = state_q != IDLE;
    assign in_ready  = in_acc;
    assign out_valid = state_q == OUT;
    assign out_data  = out_valid ? acc_q : '0;
    // datapath inputs are gated to zero outside ACC to suppress toggling
    assign mac_x     = in_acc ? in_x : '0;
    assign mac_w     = in_acc ? in_w : '0;
    assign mac_psum  = in_acc ? acc_q : '0;
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (start) begin
                acc_d   = '0;
                cnt_d   = num_grp;
                state_d = num_grp != '0 ? ACC : OUT;
            end
            ACC: if (in_valid) begin
                acc_d   = mac_out;
                cnt_d   = cnt_q - len_bw'(1);
                state_d = cnt_q == len_bw'(1) ? OUT : ACC;
            end
            OUT: state_d = out_ready ? IDLE : OUT;
            default: state_d = IDLE;
        endcase
    end
`ifdef MAC_TILE_CTRL_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;
    assign stall_cnt = stall_q;
    always_comb
        stall_d = (state_q == IDLE && start) ? 16'd0 :
                  (in_acc && !in_valid && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) stall_q <= '0;
        else stall_q <= stall_d;
`endif
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_mac_tile_ctrl.sv
// tb_mac_tile_ctrl: directed self-checking bench for mac_tile_ctrl with a behavioural 4-lane MAC datapath
module tb_mac_tile_ctrl;
    logic        clk = 0;
    logic        reset_n = 0;
    logic        start = 0;
    logic [7:0]  num_grp = 0;
    logic        busy, in_ready, out_valid;
    logic        in_valid = 0;
    logic [15:0] in_x = 0, in_w = 0;
    logic [15:0] mac_x, mac_w;
    logic [15:0] mac_psum, mac_out, out_data;
    logic        out_ready = 1;
`ifdef MAC_TILE_CTRL_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    // unsigned 4-lane dot product plus psum, wrapping at 16 bits
    always_comb begin
        mac_out = mac_psum;
        for (int i = 0; i < 4; i++)
            mac_out = mac_out + 16'(mac_x[i*4 +: 4] * mac_w[i*4 +: 4]);
    end

    mac_tile_ctrl dut (
        .clk(clk), .reset_n(reset_n), .start(start), .num_grp(num_grp), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_w(in_w),
        .mac_x(mac_x), .mac_w(mac_w), .mac_psum(mac_psum), .mac_out(mac_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef MAC_TILE_CTRL_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    function automatic logic [15:0] pack(input int a, input int b, input int c, input int d);
        return {4'(d), 4'(c), 4'(b), 4'(a)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 0;
        #2;
        total++; if ({busy, in_ready, out_valid} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {busy, in_ready, out_valid}); end
        total++; if (out_data !== 16'd0) begin bad++; $display("FAIL reset_out_data got=%0d want=0", out_data); end
        total++; if ({mac_x, mac_w, mac_psum} !== 48'd0) begin bad++; $display("FAIL reset_mac got=%h want=0", {mac_x, mac_w, mac_psum}); end
`ifdef MAC_TILE_CTRL_STALL_CNT_EN
        total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL reset_stall_cnt got=%0d want=0", stall_cnt); end
`endif
        tick();
        reset_n = 1;
        tick();
    endtask

    task automatic test_basic();
        start = 1; num_grp = 2;
        tick();
        start = 0; num_grp = 9;
        in_valid = 1; in_x = pack(1, 2, 3, 4); in_w = pack(1, 1, 1, 1);
        #1;
        total++; if ({busy, in_ready, out_valid} !== 3'b110) begin bad++; $display("FAIL basic_acc_flags got=%b want=110", {busy, in_ready, out_valid}); end
        total++; if (mac_x !== in_x || mac_w !== in_w || mac_psum !== 16'd0) begin bad++; $display("FAIL basic_passthru got=%h/%h/%0d want=%h/%h/0", mac_x, mac_w, mac_psum, in_x, in_w); end
        tick();
        in_x = pack(2, 2, 2, 2); in_w = pack(3, 0, 1, 0);
        #1;
        total++; if (mac_psum !== 16'd10) begin bad++; $display("FAIL basic_psum1 got=%0d want=10", mac_psum); end
        tick();
        in_valid = 0;
        total++; if (out_valid !== 1'b1 || out_data !== 16'd18) begin bad++; $display("FAIL basic_result got=%b/%0d want=1/18", out_valid, out_data); end
        total++; if (in_ready !== 1'b0 || mac_psum !== 16'd0 || mac_x !== 16'd0) begin bad++; $display("FAIL basic_out_gating got=%b/%0d/%h want=0/0/0", in_ready, mac_psum, mac_x); end
        tick();
        total++; if (busy !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL basic_idle got=%b/%b want=0/0", busy, out_valid); end
    endtask

    task automatic test_stalls();
        logic [5:0] pat;
        logic [15:0] exp;
        pat = 6'b101001;
        exp = 0;
        start = 1; num_grp = 3;
        tick();
        start = 0;
        in_x = pack(1, 1, 1, 1); in_w = pack(1, 1, 1, 1);
        for (int i = 0; i < 6; i++) begin
            in_valid = pat[i];
            #1;
            total++; if (mac_psum !== exp) begin bad++; $display("FAIL stall_acc_%0d got=%0d want=%0d", i, mac_psum, exp); end
            tick();
            if (pat[i]) exp = exp + 16'd4;
        end
        in_valid = 0;
        total++; if (out_valid !== 1'b1 || out_data !== 16'd12) begin bad++; $display("FAIL stall_result got=%b/%0d want=1/12", out_valid, out_data); end
`ifdef MAC_TILE_CTRL_STALL_CNT_EN
        total++; if (stall_cnt !== 16'd3) begin bad++; $display("FAIL stall_cnt got=%0d want=3", stall_cnt); end
`endif
        tick();
`ifdef MAC_TILE_CTRL_STALL_CNT_EN
        total++; if (stall_cnt !== 16'd3) begin bad++; $display("FAIL stall_cnt_hold got=%0d want=3", stall_cnt); end
`endif
    endtask

    task automatic test_zero_len();
        start = 1; num_grp = 0;
        tick();
        start = 0;
        total++; if (out_valid !== 1'b1 || out_data !== 16'd0 || in_ready !== 1'b0) begin bad++; $display("FAIL zero_result got=%b/%0d/%b want=1/0/0", out_valid, out_data, in_ready); end
`ifdef MAC_TILE_CTRL_STALL_CNT_EN
        total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL zero_stall_clear got=%0d want=0", stall_cnt); end
`endif
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL zero_idle got=%b want=0", busy); end
    endtask

    task automatic test_backpressure();
        out_ready = 0;
        start = 1; num_grp = 2;
        tick();
        start = 0;
        in_valid = 1; in_x = pack(1, 2, 3, 4); in_w = pack(1, 1, 1, 1);
        tick();
        in_x = pack(2, 2, 2, 2); in_w = pack(3, 0, 1, 0);
        tick();
        in_valid = 0;
        for (int i = 0; i < 5; i++) begin
            start = i[0]; num_grp = 5;
            total++; if (out_valid !== 1'b1 || out_data !== 16'd18) begin bad++; $display("FAIL bp_hold_%0d got=%b/%0d want=1/18", i, out_valid, out_data); end
            tick();
        end
        start = 0; out_ready = 1;
        tick();
        total++; if (busy !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL bp_release got=%b/%b want=0/0", busy, out_valid); end
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_no_queue got=%b want=0", busy); end
    endtask

    task automatic test_reset_mid();
        start = 1; num_grp = 4;
        tick();
        start = 0;
        in_valid = 1; in_x = pack(3, 3, 3, 3); in_w = pack(3, 3, 3, 3);
        tick();
        tick();
        #2;
        reset_n = 0;
        #1;
        total++; if ({busy, in_ready, out_valid} !== 3'b000 || out_data !== 16'd0) begin bad++; $display("FAIL midrst_flags got=%b/%0d want=000/0", {busy, in_ready, out_valid}, out_data); end
        total++; if ({mac_x, mac_w, mac_psum} !== 48'd0) begin bad++; $display("FAIL midrst_mac got=%h want=0", {mac_x, mac_w, mac_psum}); end
        in_valid = 0;
        tick();
        reset_n = 1;
        tick();
        start = 1; num_grp = 1;
        tick();
        start = 0;
        in_valid = 1; in_x = pack(2, 2, 2, 2); in_w = pack(2, 2, 2, 2);
        #1;
        total++; if (mac_psum !== 16'd0) begin bad++; $display("FAIL midrst_acc_clear got=%0d want=0", mac_psum); end
        tick();
        in_valid = 0;
        total++; if (out_valid !== 1'b1 || out_data !== 16'd16) begin bad++; $display("FAIL midrst_result got=%b/%0d want=1/16", out_valid, out_data); end
        tick();
    endtask

    task automatic test_wrap();
        start = 1; num_grp = 255;
        tick();
        start = 0;
        in_valid = 1; in_x = 16'hFFFF; in_w = 16'hFFFF;
        for (int i = 0; i < 255; i++) begin
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL wrap_early_%0d got=%b want=0", i, out_valid); end
            tick();
        end
        in_valid = 0;
        // 255 beats * 4 * 225 = 229500, modulo 65536 = 32892
        total++; if (out_valid !== 1'b1 || out_data !== 16'd32892) begin bad++; $display("FAIL wrap_result got=%b/%0d want=1/32892", out_valid, out_data); end
`ifdef MAC_TILE_CTRL_STALL_CNT_EN
        total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL wrap_stall_cnt got=%0d want=0", stall_cnt); end
`endif
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL wrap_idle got=%b want=0", busy); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stalls();
        test_zero_len();
        test_backpressure();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
